// File: rtl/alu_pwr_seq_if.sv
// Request/status bundle between the system power manager and the ALU power sequencer.
// The manager drives the requests and busy flag; the sequencer drives the domain controls.
interface alu_pwr_seq_if;
    logic       sleep_req;
    logic       wake_req;
    logic       alu_busy;
    logic       alu_pwr_en;
    logic       iso_en;
    logic       alu_rst_n;
    logic       start_gnt;
    logic [2:0] pwr_state;
    logic       pwr_done;
    logic       err_timeout;

    modport master (
        output sleep_req, wake_req, alu_busy,
        input  alu_pwr_en, iso_en, alu_rst_n, start_gnt, pwr_state, pwr_done, err_timeout
    );

    modport slave (
        input  sleep_req, wake_req, alu_busy,
        output alu_pwr_en, iso_en, alu_rst_n, start_gnt, pwr_state, pwr_done, err_timeout
    );
endinterface

// File: rtl/alu_pwr_seq.sv
// Power sequencer for the gated ALU domain: orders power, reset and isolation on
// power-up/down, drains in-flight work before isolating, and flags drain timeouts.
module alu_pwr_seq #(
    parameter int unsigned RAMP_CYC  = 4,
    parameter int unsigned RST_CYC   = 2,
    parameter int unsigned ISO_CYC   = 3,
    parameter int unsigned DRAIN_MAX = 255,
    parameter int unsigned CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    alu_pwr_seq_if.slave pif
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RAMP    = 3'd1,
        ST_RST_REL = 3'd2,
        ST_ON      = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_ISOLATE = 3'd5
    } pwr_state_e;

    // Dwell counters load max(param,1)-1 so a zero parameter still yields one cycle
    localparam int unsigned RAMP_LD_I    = (RAMP_CYC > 0) ? RAMP_CYC - 1 : 0;
    localparam int unsigned RST_LD_I     = (RST_CYC > 0) ? RST_CYC - 1 : 0;
    localparam int unsigned ISO_LD_I     = (ISO_CYC > 0) ? ISO_CYC - 1 : 0;
    localparam int unsigned DRAIN_LAST_I = (DRAIN_MAX > 0) ? DRAIN_MAX - 1 : 0;
    localparam bit          DRAIN_TO_EN  = (DRAIN_MAX != 0);

    localparam logic [CNT_W-1:0] RAMP_LD    = CNT_W'(RAMP_LD_I);
    localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_LD_I);
    localparam logic [CNT_W-1:0] ISO_LD     = CNT_W'(ISO_LD_I);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LAST_I);
    localparam logic [CNT_W-1:0] DRAIN_SAT  = DRAIN_TO_EN ? CNT_W'(DRAIN_MAX) : '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    pwr_state_e       state_q;
    pwr_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_c;
    logic             pwr_en_d;
    logic             iso_en_d;
    logic             rst_n_d;
    logic             gnt_d;
    logic             done_d;

    // Next-state and dwell counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (pif.wake_req) begin
                    state_d = ST_RAMP;
                    cnt_d   = RAMP_LD;
                end
            end
            ST_RAMP: begin
                if (cnt_q == '0) begin
                    state_d = ST_RST_REL;
                    cnt_d   = RST_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RST_REL: begin
                if (cnt_q == '0) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ON: begin
                if (pif.sleep_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Abort beats drain completion; timeout only matters while still busy
                if (pif.wake_req && !pif.sleep_req) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else if (!pif.alu_busy) begin
                    state_d = ST_ISOLATE;
                    cnt_d   = ISO_LD;
                end else if (DRAIN_TO_EN && (cnt_q >= DRAIN_LAST)) begin
                    state_d   = ST_ISOLATE;
                    cnt_d     = ISO_LD;
                    timeout_c = 1'b1;
                end else if (cnt_q != DRAIN_SAT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ISOLATE: begin
                if (cnt_q == '0) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the state being entered, so outputs switch on the entering edge
    always_comb begin
        pwr_en_d = 1'b0;
        iso_en_d = 1'b1;
        rst_n_d  = 1'b0;
        gnt_d    = 1'b0;
        case (state_d)
            ST_RAMP: begin
                pwr_en_d = 1'b1;
            end
            ST_RST_REL, ST_ISOLATE: begin
                pwr_en_d = 1'b1;
                rst_n_d  = 1'b1;
            end
            ST_ON: begin
                pwr_en_d = 1'b1;
                iso_en_d = 1'b0;
                rst_n_d  = 1'b1;
                gnt_d    = 1'b1;
            end
            ST_DRAIN: begin
                pwr_en_d = 1'b1;
                iso_en_d = 1'b0;
                rst_n_d  = 1'b1;
            end
            default: begin
                pwr_en_d = 1'b0;
            end
        endcase
        done_d = (state_d != state_q) && ((state_d == ST_ON) || (state_d == ST_OFF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_OFF;
            cnt_q           <= '0;
            pif.alu_pwr_en  <= 1'b0;
            pif.iso_en      <= 1'b1;
            pif.alu_rst_n   <= 1'b0;
            pif.start_gnt   <= 1'b0;
            pif.pwr_state   <= 3'(ST_OFF);
            pif.pwr_done    <= 1'b0;
            pif.err_timeout <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pif.alu_pwr_en <= pwr_en_d;
            pif.iso_en     <= iso_en_d;
            pif.alu_rst_n  <= rst_n_d;
            pif.start_gnt  <= gnt_d;
            pif.pwr_state  <= 3'(state_d);
            pif.pwr_done   <= done_d;
            if (timeout_c) begin
                pif.err_timeout <= 1'b1;
            end
        end
    end

endmodule
